// File: rtl/eth_pkg.sv
// Shared constants, state encoding and CRC helper for the serial Ethernet link.
package eth_pkg;

    localparam logic [63:0] PREAMBLE_SFD = 64'hAAAAAAAAAAAAAAAB;
    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam int          PRE_BITS     = 64;
    localparam int          HDR_BITS     = 96;
    localparam int          LEN_BITS     = 16;
    localparam int          FCS_BITS     = 32;
    localparam int          MAX_PAYLOAD  = 1500;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_LEN  = 3'd3,
        ST_PAY  = 3'd4,
        ST_FCS  = 3'd5
    } eth_state_e;

    // One serial CRC step: MSB-first, no reflection, x^32 term implied.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic        b,
                                               input logic [31:0] poly);
        logic fb;
        fb = crc[31] ^ b;
        return {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/eth_crc32_serial.sv
// Bit-serial CRC-32 register, shared between transmit and receive paths.
module eth_crc32_serial
    import eth_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next remainder: clear wins over a data bit, otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 32'h0000_0000;
        end else if (en_i) begin
            crc_d = crc32_step(crc_q, bit_i, POLY);
        end else begin
            crc_d = crc_q;
        end
    end

    // Remainder register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= 32'h0000_0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/ethernet_tx.sv
// Serial frame transmitter: preamble, addresses, length, payload, CRC, MSB first.
// Every output is a register; TxBit/TxEn describe the bit currently on the line.
module ethernet_tx
    import eth_pkg::*;
#(
    parameter int          MAX_LEN  = MAX_PAYLOAD,
    parameter logic [63:0] PREAMBLE = PREAMBLE_SFD,
    parameter logic [31:0] CRC_POLY = CRC32_POLY
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [15:0] Length,
    input  logic [47:0] DestMac,
    input  logic [47:0] SrcMac,
    input  logic [7:0]  DataIn,
    input  logic        DataValid,
    output logic        DataReady,
    output logic        TxBit,
    output logic        TxEn,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    eth_state_e  state_q, state_d;
    logic [13:0] cnt_q, cnt_d, nxt_cnt_s, pay_last_s;
    logic [95:0] hdr_q, hdr_d;
    logic [15:0] len_q, len_d, fetched_q, fetched_d;
    logic [7:0]  hold_q, hold_d, shift_q, shift_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_bit_q, tx_bit_d, tx_en_q, tx_en_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        ready_q, ready_d;
    logic        crc_clr_s, crc_en_s, crc_bit_s, xfer_s;
    logic [31:0] crc_s;

    eth_crc32_serial #(.POLY(CRC_POLY)) u_crc (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .clear_i (crc_clr_s),
        .en_i    (crc_en_s),
        .bit_i   (crc_bit_s),
        .crc_o   (crc_s)
    );

    assign nxt_cnt_s  = cnt_q + 14'd1;
    assign pay_last_s = {len_q[10:0], 3'b000} - 14'd1;
    assign xfer_s     = DataValid & ready_q;

    // Frame sequencing: choose the next line bit, move payload bytes, feed the CRC.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        len_d       = len_q;
        fetched_d   = fetched_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        tx_bit_d    = 1'b0;
        tx_en_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        crc_clr_s   = 1'b0;
        crc_en_s    = 1'b0;
        crc_bit_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Length <= MAX_LEN_W) begin
                        state_d     = ST_PRE;
                        cnt_d       = 14'd0;
                        hdr_d       = {DestMac, SrcMac};
                        len_d       = Length;
                        fetched_d   = 16'd0;
                        hold_full_d = 1'b0;
                        crc_clr_s   = 1'b1;
                        tx_bit_d    = PREAMBLE[63];
                        tx_en_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == 14'd63) begin
                    state_d  = ST_HDR;
                    cnt_d    = 14'd0;
                    tx_bit_d = hdr_q[95];
                end else begin
                    cnt_d    = nxt_cnt_s;
                    tx_bit_d = PREAMBLE[6'd63 - nxt_cnt_s[5:0]];
                end
            end
            ST_HDR: begin
                tx_en_d = 1'b1;
                if (cnt_q == 14'd95) begin
                    state_d  = ST_LEN;
                    cnt_d    = 14'd0;
                    tx_bit_d = len_q[15];
                end else begin
                    cnt_d    = nxt_cnt_s;
                    tx_bit_d = hdr_q[7'd95 - nxt_cnt_s[6:0]];
                end
            end
            ST_LEN, ST_PAY: begin
                tx_en_d = 1'b1;
                if ((state_q == ST_LEN && cnt_q == 14'd15 && len_q == 16'd0) ||
                    (state_q == ST_PAY && cnt_q == pay_last_s)) begin
                    // The CRC already holds every payload bit put on the line.
                    state_d  = ST_FCS;
                    cnt_d    = 14'd0;
                    tx_bit_d = crc_s[31];
                end else if (state_q == ST_LEN && cnt_q != 14'd15) begin
                    cnt_d    = nxt_cnt_s;
                    tx_bit_d = len_q[4'd15 - nxt_cnt_s[3:0]];
                end else if (state_q == ST_PAY && nxt_cnt_s[2:0] != 3'd0) begin
                    cnt_d     = nxt_cnt_s;
                    tx_bit_d  = shift_q[7];
                    shift_d   = {shift_q[6:0], 1'b0};
                    crc_en_s  = 1'b1;
                    crc_bit_s = shift_q[7];
                end else if (hold_full_q) begin
                    // Byte boundary: the held byte becomes the active shifter.
                    state_d     = ST_PAY;
                    cnt_d       = (state_q == ST_LEN) ? 14'd0 : nxt_cnt_s;
                    tx_bit_d    = hold_q[7];
                    shift_d     = {hold_q[6:0], 1'b0};
                    hold_full_d = 1'b0;
                    crc_en_s    = 1'b1;
                    crc_bit_s   = hold_q[7];
                end else begin
                    // Underrun: nothing to send, abandon the frame.
                    state_d = ST_IDLE;
                    cnt_d   = 14'd0;
                    tx_en_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_FCS: begin
                if (cnt_q == 14'd31) begin
                    state_d = ST_IDLE;
                    cnt_d   = 14'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = nxt_cnt_s;
                    tx_bit_d = crc_s[5'd31 - nxt_cnt_s[4:0]];
                    tx_en_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 14'd0;
            end
        endcase
        // A transfer can only happen while the hold buffer is empty, so it never
        // collides with a boundary that consumes the held byte.
        if (xfer_s) begin
            hold_d      = DataIn;
            hold_full_d = 1'b1;
            fetched_d   = fetched_q + 16'd1;
        end else begin
            hold_d = hold_d;
        end
    end

    // Registered status outputs follow the next state.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        ready_d = busy_d & ~hold_full_d & (fetched_d < len_d);
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 14'd0;
            hdr_q       <= 96'd0;
            len_q       <= 16'd0;
            fetched_q   <= 16'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            tx_bit_q    <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            len_q       <= len_d;
            fetched_q   <= fetched_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign DataReady = ready_q;
    assign TxBit     = tx_bit_q;
    assign TxEn      = tx_en_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_ethernet_tx.sv
// Directed bench for ethernet_tx: captures the serial stream and checks each field.
module tb_ethernet_tx;

    logic        Clk = 1'b0;
    logic        Rst, Start, DataValid;
    logic [15:0] Length;
    logic [47:0] DestMac, SrcMac;
    logic [7:0]  DataIn;
    logic        DataReady, TxBit, TxEn, Busy, Done, Err;

    ethernet_tx dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Length(Length),
        .DestMac(DestMac), .SrcMac(SrcMac), .DataIn(DataIn),
        .DataValid(DataValid), .DataReady(DataReady), .TxBit(TxBit),
        .TxEn(TxEn), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int   n_cmp = 0;
    int   n_err = 0;
    logic cap[$];
    int   en_cnt, done_cnt, err_cnt, ready_cnt, first_en, last_en;
    logic busy_end, ended;
    logic [7:0] pay [0:7];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] field(input int start, input int w);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (start + i < cap.size()) r = {r[94:0], cap[start + i]};
            else                        r = {r[94:0], 1'bx};
        end
        return r;
    endfunction

    // Reference remainder over the first n payload bytes, then optionally extra bits.
    function automatic logic [31:0] model_crc(input int n, input logic [31:0] tail, input bit use_tail);
        logic [31:0] c;
        logic        fb;
        c = 32'h0;
        for (int k = 0; k < n; k++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[31] ^ pay[k][b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        if (use_tail)
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ tail[b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        return c;
    endfunction

    task automatic run_frame(input int len, input int stall_at, input logic [47:0] dm, input logic [47:0] sm);
        int idx;
        cap.delete();
        en_cnt = 0; done_cnt = 0; err_cnt = 0; ready_cnt = 0;
        first_en = -1; last_en = -1; ended = 1'b0; idx = 0;
        @(negedge Clk);
        Start = 1'b1; Length = len[15:0]; DestMac = dm; SrcMac = sm; DataValid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (TxEn) begin
                cap.push_back(TxBit);
                en_cnt++;
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (DataReady) ready_cnt++;
            if (Done) done_cnt++;
            if (Err)  err_cnt++;
            busy_end = Busy;
            if (Done || Err) begin
                ended = 1'b1;
                break;
            end
            DataValid = (idx < len) && (idx < stall_at);
            DataIn    = (idx < 8) ? pay[idx] : 8'h00;
            if (DataValid && DataReady) idx++;
        end
        DataValid = 1'b0;
        chk("frame_ended", ended, 1);
        chk("txen_contiguous", last_en - first_en + 1, en_cnt);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Length = 16'd0; DestMac = 48'd0; SrcMac = 48'd0;
        DataIn = 8'd0; DataValid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {DataReady, TxBit, TxEn, Busy, Done, Err}, 0);
        Rst = 1'b0;

        // 1: single byte 0x01, zero addresses
        pay[0] = 8'h01;
        run_frame(1, 99, 48'd0, 48'd0);
        chk("t1_en_cycles", en_cnt, 216);
        chk("t1_preamble", field(0, 64), 96'h0000_0000_AAAA_AAAA_AAAA_AAAB);
        chk("t1_header", field(64, 96), 96'd0);
        chk("t1_length", field(160, 16), 96'h0001);
        chk("t1_payload", field(176, 8), 96'h01);
        chk("t1_fcs", field(184, 32), 96'h04C11DB7);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", err_cnt, 0);
        @(negedge Clk);
        chk("t1_done_one_cycle", Done, 0);

        // 2: empty payload
        run_frame(0, 99, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654);
        chk("t2_en_cycles", en_cnt, 208);
        chk("t2_header", field(64, 96), 96'h0123_4567_89AB_FEDC_BA98_7654);
        chk("t2_length", field(160, 16), 96'h0000);
        chk("t2_fcs", field(176, 32), 96'd0);
        chk("t2_ready_never", ready_cnt, 0);
        chk("t2_done", done_cnt, 1);

        // 3: three bytes, FCS must make the payload divisible by the polynomial
        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
        run_frame(3, 99, 48'h1111_2222_3333, 48'h4444_5555_6666);
        chk("t3_en_cycles", en_cnt, 232);
        chk("t3_length", field(160, 16), 96'h0003);
        chk("t3_payload", field(176, 24), 96'hA53CFF);
        chk("t3_fcs_model", field(200, 32), model_crc(3, 32'h0, 1'b0));
        chk("t3_divisible", model_crc(3, field(200, 32), 1'b1), 0);
        chk("t3_done", done_cnt, 1);

        // 4: underrun after the second byte
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        run_frame(4, 2, 48'd5, 48'd6);
        chk("t4_en_cycles", en_cnt, 192);
        chk("t4_err", err_cnt, 1);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_busy_low", busy_end, 0);
        @(negedge Clk);
        chk("t4_err_one_cycle", {Err, TxEn}, 0);

        // 5: oversized length rejected, then a normal 2-byte frame
        @(negedge Clk);
        Start = 1'b1; Length = 16'd1501;
        @(negedge Clk);
        Start = 1'b0;
        chk("t5_reject", {TxEn, Err, Busy}, 3'b010);
        @(negedge Clk);
        chk("t5_reject_after", {TxEn, Err, Busy}, 3'b000);
        pay[0] = 8'h12; pay[1] = 8'h34;
        run_frame(2, 99, 48'd0, 48'd0);
        chk("t5_en_cycles", en_cnt, 224);
        chk("t5_payload", field(176, 16), 96'h1234);
        chk("t5_fcs", field(192, 32), model_crc(2, 32'h0, 1'b0));
        chk("t5_done", done_cnt, 1);

        // 6: reset in the 100th TxEn cycle, then a clean frame
        pay[0] = 8'h55; pay[1] = 8'h66; pay[2] = 8'h77; pay[3] = 8'h88; pay[4] = 8'h99;
        @(negedge Clk);
        Start = 1'b1; Length = 16'd5;
        en_cnt = 0; ended = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            DataValid = 1'b1; DataIn = pay[0];
            if (TxEn) en_cnt++;
            if (en_cnt == 100) begin
                ended = 1'b1;
                break;
            end
        end
        chk("t6_reached_100", ended, 1);
        Rst = 1'b1; DataValid = 1'b0;
        @(negedge Clk);
        chk("t6_reset_outputs", {DataReady, TxBit, TxEn, Busy, Done, Err}, 0);
        Rst = 1'b0;
        pay[0] = 8'hC3;
        run_frame(1, 99, 48'hABCD_EF01_2345, 48'd0);
        chk("t6_en_cycles", en_cnt, 216);
        chk("t6_preamble", field(0, 64), 96'h0000_0000_AAAA_AAAA_AAAA_AAAB);
        chk("t6_header", field(64, 48), 96'hABCD_EF01_2345);
        chk("t6_fcs", field(184, 32), model_crc(1, 32'h0, 1'b0));
        chk("t6_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ethernet_tx.md
Name: ethernet_tx

Overview:
Serial Ethernet-style frame transmitter. It is the transmit end of the link whose receiver expects this bitstream:
- 64-bit preamble/SFD.
- 96-bit address header.
- 16-bit EtherType carrying the payload length in bytes.
- Payload.
- 32-bit CRC remainder.

Payload bytes are pulled over a byte-wide valid/ready interface and emitted one bit per clock, MSB first. The block sits between the framing/payload source and the serial line driving the receiver's Input1.

Parameters:
MAX_LEN, 1500, largest accepted payload length in bytes (8*MAX_LEN ≤ 12000 bits).
PREAMBLE, 64'hAAAAAAAAAAAAAAAB, preamble+SFD pattern sent first, MSB first.
CRC_POLY, 32'h04C11DB7, generator polynomial 0x1_04C11DB7 with the x^32 term implied.

Ports:
Clk  in  1  clock; all logic on posedge.
Rst  in  1  synchronous reset, active-high.
Start  in  1  frame request, sampled only in IDLE.
Length  in  16  payload byte count, captured with Start.
DestMac  in  48  destination address, captured with Start.
SrcMac  in  48  source address, captured with Start.
DataIn  in  8  payload byte.
DataValid  in  1  DataIn valid.
DataReady  out  1  block accepts a byte this cycle.
TxBit  out  1  serial line bit.
TxEn  out  1  TxBit is part of a frame.
Busy  out  1  frame in progress.
Done  out  1  one-cycle pulse after the last CRC bit.
Err  out  1  one-cycle pulse on rejected start or underrun.

Behaviour:
- Reset: the single synchronous active-high reset is Rst, sampled on posedge Clk. While it is asserted, every output is 0, the state is IDLE, and the CRC, counters and hold buffer are cleared. Reset mid-frame aborts immediately; TxEn is 0 on the next edge.
- States: IDLE -> PRE (64 bits) -> HDR (96 bits: DestMac then SrcMac) -> LEN (16 bits: Length) -> PAY (8*Length bits) -> FCS (32 bits) -> IDLE.
  - PAY is skipped when Length = 0.
  - A single bit counter indexes each field; all fields are sent MSB first.
- Start:
  - Start=1 in IDLE with Length ≤ MAX_LEN: capture the inputs and go to PRE. PREAMBLE[63] appears on TxBit with TxEn=1 on the next cycle.
  - Length > MAX_LEN: no frame, Err pulses next cycle, stay IDLE.
  - Start is ignored while Busy.
- Timing: TxEn stays high for exactly 208 + 8*Length consecutive cycles. Busy = (state != IDLE). Done pulses in the cycle after the last FCS bit, coincident with the return to IDLE. Back-to-back frames are allowed: Start may be asserted in that same IDLE cycle.
- Payload fetch uses a 1-byte hold buffer.
  - DataReady = Busy & ~hold_full & (bytes_fetched < Length).
  - A transfer occurs on DataValid & DataReady; DataIn is ignored otherwise.
  - At each PAY byte boundary (including the first PAY bit), the hold byte moves into the bit shifter.
  - If the hold buffer is empty at a boundary, the frame is an underrun: TxEn drops next cycle, Err pulses, return to IDLE, no Done.
- CRC:
  - Covers payload bits only. Initial value 0, no reflection, no final XOR.
  - Per payload bit b: fb = crc[31]^b; crc = {crc[30:0],0} ^ (fb ? CRC_POLY : 0).
  - FCS sends crc[31] down to crc[0].
  - Payload followed by FCS is exactly divisible by 0x1_04C11DB7, matching the receiver's check.
  - Length = 0 gives FCS = 32 zero bits.
- Widths: the bit counter is ≥ 14 bits, bytes_fetched is 16 bits, and no wrap is possible within MAX_LEN.

Decomposition:
- Shared package eth_pkg:
  - constants PREAMBLE_SFD, CRC32_POLY, HDR_BITS=96, LEN_BITS=16, FCS_BITS=32, MAX_PAYLOAD=1500;
  - the state enum typedef.
- The receiver reuses these constants.
- One natural sub-module, eth_crc32_serial: inputs clear, enable, bit; output the 32-bit crc. It is shared with a future serial-CRC receiver rewrite.

Test Plan:
1. Length=1, DataIn=8'h01 ready early, both MACs 0 -> 216 TxEn cycles with the stream below, then Done pulse:
   - bits 0..63 = AAAAAAAAAAAAAAAB;
   - 96 zeros;
   - 16'h0001;
   - 00000001;
   - FCS 32'h04C11DB7.
2. Length=0 -> 208 TxEn cycles, FCS all zeros, DataReady never asserted, Done pulses.
3. Length=3, bytes A5,3C,FF -> the captured stream fed to the existing Ethernet receiver gives Z[23:0]=24'hA53CFF, and the receiver's CRC check passes with no correction.
4. Length=4 with DataValid withheld after the 2nd byte -> TxEn drops one cycle after the 3rd byte boundary, Err=1 for 1 cycle, no Done, Busy=0.
5. Length=1501 -> no TxEn, Err pulse next cycle; a subsequent Length=2 frame is sent normally.
6. Rst asserted in the 100th TxEn cycle -> next cycle all outputs 0; a new Start afterwards produces a clean frame beginning with PREAMBLE.
